// File: rtl/traj_point_sched.sv
// traj_point_sched: buffers tracker points in a small FIFO and releases at
// most one point per frame to the trajectory overlay, only at the start of
// vertical blanking. The displayed point is retired (driven to the 3FF/3FF
// off-screen sentinel) after HOLD_FRAMES frames without a new point.
//
// Build option: define TRAJ_DECIMATE_EN to drop incoming points that lie
// closer than MIN_DIST (Manhattan distance) to the last stored point.
//
// State table
//   state | meaning
//   IDLE  | waiting for the blank edge of the current frame
//   ISSUE | one cycle: head point is on the outputs with the load strobe
//   AGE   | one cycle: frame counter stepped, retire strobe if it expired
//   SHOW  | release done for this frame, waiting for active video
module traj_point_sched #(
   parameter int DEPTH       = 4,
   parameter int HOLD_FRAMES = 30,
   parameter int FRAME_H     = 480,
   parameter int MIN_DIST    = 2
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [9:0]               i_ptH,
   input  logic [9:0]               i_ptV,
   input  logic                     i_ptValid,
   output logic                     o_ptReady,
   input  logic [9:0]               i_v,
   input  logic                     i_rendering,
   output logic [9:0]               o_pointH,
   output logic [9:0]               o_pointV,
   output logic                     o_pointVAL,
   output logic                     o_overflow,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(HOLD_FRAMES + 1);
   localparam logic [9:0] SENTINEL = 10'h3FF;

   // Reject parameter sets the pointer arithmetic cannot support.
   if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || MIN_DIST < 0 || MIN_DIST > 2047) begin : g_bad_param
      $error("traj_point_sched: unsupported DEPTH or MIN_DIST");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_AGE   = 2'd2,
      S_SHOW  = 2'd3
   } state_t;

   state_t          state_q;
   logic [9:0]      mem_h_q [DEPTH];
   logic [9:0]      mem_v_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]   level_q, level_d;
   logic            ready_q, ready_d;
   logic            ovf_q, ovf_d;
   logic            blank_q;
   logic [CW-1:0]   cnt_q, cnt_inc;
   logic [9:0]      point_h_q, point_v_q;
   logic            val_q;

   logic            full, empty, blank_now, blank_edge;
   logic            pop, hs, push;

   assign full       = (level_q == LW'(DEPTH));
   assign empty      = (level_q == '0);
   assign blank_now  = (i_v >= 10'(FRAME_H));
   assign blank_edge = blank_now & ~blank_q;

   // The release cycle frees the head slot, so a point offered in that same
   // cycle is taken even if the FIFO was full and ready was low.
   assign pop = (state_q == S_IDLE) & blank_edge & ~empty;
   assign hs  = i_ptValid & (ready_q | pop);

`ifdef TRAJ_DECIMATE_EN
   logic [9:0]  ref_h_q, ref_v_q;
   logic [10:0] diff_h, diff_v;
   logic [11:0] dist;
   logic        too_close;

   // Manhattan distance to the last stored point, 11-bit unsigned diffs.
   always_comb begin
      diff_h    = (i_ptH >= ref_h_q) ? ({1'b0, i_ptH} - {1'b0, ref_h_q}) : ({1'b0, ref_h_q} - {1'b0, i_ptH});
      diff_v    = (i_ptV >= ref_v_q) ? ({1'b0, i_ptV} - {1'b0, ref_v_q}) : ({1'b0, ref_v_q} - {1'b0, i_ptV});
      dist      = {1'b0, diff_h} + {1'b0, diff_v};
      too_close = (dist < 12'(MIN_DIST));
   end

   assign push = hs & ~too_close;

   // Reference point tracks the last point actually written to the FIFO.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ref_h_q <= SENTINEL;
         ref_v_q <= SENTINEL;
      end else if (push) begin
         ref_h_q <= i_ptH;
         ref_v_q <= i_ptV;
      end
   end
`else
   assign push = hs;
`endif

   // Next occupancy; ready is registered from it so it reflects the new level.
   always_comb begin
      level_d = level_q + LW'(push) - LW'(pop);
      ready_d = (level_d != LW'(DEPTH));
      ovf_d   = ovf_q | (i_ptValid & full & ~pop);
   end

   // FIFO storage, pointers, occupancy, overflow flag and blank detector.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_h_q[i] <= '0;
            mem_v_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ready_q  <= 1'b0;
         ovf_q    <= 1'b0;
         blank_q  <= 1'b0;
      end else begin
         if (push) begin
            mem_h_q[wr_ptr_q] <= i_ptH;
            mem_v_q[wr_ptr_q] <= i_ptV;
            wr_ptr_q          <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         level_q <= level_d;
         ready_q <= ready_d;
         ovf_q   <= ovf_d;
         blank_q <= blank_now;
      end
   end

   assign cnt_inc = (cnt_q == CW'(HOLD_FRAMES)) ? cnt_q : cnt_q + 1'b1;

   // Release sequencer. Outputs are loaded on the edge that enters ISSUE or
   // AGE, so the strobe and the new coordinates are visible during that state.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         point_h_q <= SENTINEL;
         point_v_q <= SENTINEL;
         val_q     <= 1'b0;
      end else begin
         val_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (blank_edge) begin
                  if (!empty) begin
                     state_q   <= S_ISSUE;
                     point_h_q <= mem_h_q[rd_ptr_q];
                     point_v_q <= mem_v_q[rd_ptr_q];
                     val_q     <= 1'b1;
                     cnt_q     <= '0;
                  end else begin
                     state_q <= S_AGE;
                     cnt_q   <= cnt_inc;
                     if (cnt_inc == CW'(HOLD_FRAMES) &&
                         !(point_h_q == SENTINEL && point_v_q == SENTINEL)) begin
                        point_h_q <= SENTINEL;
                        point_v_q <= SENTINEL;
                        val_q     <= 1'b1;
                     end
                  end
               end
            end
            S_ISSUE: state_q <= S_SHOW;
            S_AGE:   state_q <= S_SHOW;
            S_SHOW: begin
               if (i_rendering) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_ptReady  = ready_q;
   assign o_pointH   = point_h_q;
   assign o_pointV   = point_v_q;
   assign o_pointVAL = val_q;
   assign o_overflow = ovf_q;
   assign o_level    = level_q;

endmodule
